// File: rtl/capture_sequencer.sv
// capture_sequencer: sequences one acquisition (arm, flush, trigger, strobe, fill, drain) of the sample storage.
// Optional no-progress timeout in WAIT_FULL/DRAIN is compiled in when CAPTURE_TIMEOUT_EN is defined.
module capture_sequencer #(
  parameter int THRESH_W       = 12,
  parameter int COUNT_W        = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ArmCmd,
  input  logic                AbortCmd,
  input  logic                AutoTrigger,
  input  logic                TriggerIn,
  input  logic [THRESH_W-1:0] SampleWords,
  input  logic [1:0]          StorageState,
  input  logic                StorageReady,
  input  logic                StorageValid,
  input  logic [7:0]          StorageData,
  output logic                StorageReset,
  output logic                WriteStrobe,
  output logic [THRESH_W-1:0] ProgFullThresh,
  output logic                StorageReadEnable,
  output logic [7:0]          TxData,
  output logic                TxValid,
  input  logic                TxReady,
  output logic [COUNT_W-1:0]  ByteCount,
  output logic                Busy,
  output logic                Done,
  output logic                Error,
  output logic [1:0]          ErrorCode,
  output logic [2:0]          CtrlState
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FLUSH     = 3'd1,
    ARMED     = 3'd2,
    STROBE    = 3'd3,
    WAIT_FULL = 3'd4,
    DRAIN     = 3'd5,
    DONE      = 3'd6,
    ERROR     = 3'd7
  } state_t;

  localparam logic [THRESH_W-1:0] THR_MIN = THRESH_W'(2);
  localparam logic [THRESH_W-1:0] THR_MAX = {THRESH_W{1'b1}} - THRESH_W'(2);

  state_t     state;
  logic [1:0] seq_cnt;
  logic       trig_q;
  logic       trig_seen;
  logic       trig_rise;
  logic       pending;
  logic [2:0] pend_cnt;
  logic       abort_hit;
  logic       tmo_hit;

  assign trig_rise = TriggerIn & ~trig_q;
  assign abort_hit = AbortCmd & (state != IDLE) & (state != DONE) & (state != ERROR);
  assign CtrlState = state;

`ifdef CAPTURE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             in_wait;

  assign in_wait = (state == WAIT_FULL) | (state == DRAIN);
  assign tmo_hit = in_wait & (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // no-progress counter: restarts on entry to WAIT_FULL/DRAIN and on every byte the sink accepts
  always_ff @(posedge Clock) begin
    if (Reset || !in_wait || tmo_hit) begin
      tmo_cnt <= '0;
    end else if ((state == WAIT_FULL && StorageState == 2'b11) || (state == DRAIN && TxValid && TxReady)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // controller: state, read engine and every registered output
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state             <= IDLE;
      seq_cnt           <= 2'd0;
      trig_q            <= 1'b0;
      trig_seen         <= 1'b0;
      pending           <= 1'b0;
      pend_cnt          <= 3'd0;
      StorageReset      <= 1'b0;
      WriteStrobe       <= 1'b0;
      ProgFullThresh    <= THR_MIN;
      StorageReadEnable <= 1'b0;
      TxData            <= 8'd0;
      TxValid           <= 1'b0;
      ByteCount         <= '0;
      Busy              <= 1'b0;
      Done              <= 1'b0;
      Error             <= 1'b0;
      ErrorCode         <= 2'b00;
    end else begin
      trig_q            <= TriggerIn;
      StorageReadEnable <= 1'b0;
      Done              <= 1'b0;
      Error             <= 1'b0;
      if (abort_hit || tmo_hit) begin
        state        <= ERROR;
        Error        <= 1'b1;
        ErrorCode    <= abort_hit ? 2'b01 : 2'b10;
        StorageReset <= 1'b1;
        seq_cnt      <= 2'd0;
        WriteStrobe  <= 1'b0;
        TxValid      <= 1'b0;
        pending      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ArmCmd && !AbortCmd) begin
              state        <= FLUSH;
              Busy         <= 1'b1;
              StorageReset <= 1'b1;
              seq_cnt      <= 2'd0;
              ByteCount    <= '0;
              ErrorCode    <= 2'b00;
              if (SampleWords < THR_MIN) begin
                ProgFullThresh <= THR_MIN;
              end else if (SampleWords > THR_MAX) begin
                ProgFullThresh <= THR_MAX;
              end else begin
                ProgFullThresh <= SampleWords;
              end
            end
          end
          FLUSH: begin
            if (seq_cnt == 2'd3) begin
              StorageReset <= 1'b0;
              trig_seen    <= 1'b0;
              state        <= ARMED;
            end else begin
              seq_cnt <= seq_cnt + 2'd1;
            end
          end
          ARMED: begin
            // a level already high on entry never produces trig_rise, so it cannot qualify
            if (trig_rise) begin
              trig_seen <= 1'b1;
            end
            if (StorageState == 2'b01 && (AutoTrigger || trig_seen || trig_rise)) begin
              WriteStrobe <= 1'b1;
              seq_cnt     <= 2'd0;
              state       <= STROBE;
            end
          end
          STROBE: begin
            if (seq_cnt == 2'd1) begin
              WriteStrobe <= 1'b0;
              state       <= WAIT_FULL;
            end else begin
              seq_cnt <= seq_cnt + 2'd1;
            end
          end
          WAIT_FULL: begin
            if (StorageState == 2'b11) begin
              state <= DRAIN;
            end
          end
          DRAIN: begin
            if (TxValid) begin
              if (TxReady) begin
                TxValid <= 1'b0;
                if (ByteCount != {COUNT_W{1'b1}}) begin
                  ByteCount <= ByteCount + COUNT_W'(1);
                end
              end
            end else if (pending) begin
              if (StorageValid) begin
                TxData  <= StorageData;
                TxValid <= 1'b1;
                pending <= 1'b0;
              end else if (pend_cnt == 3'd7) begin
                pending <= 1'b0;
              end else begin
                pend_cnt <= pend_cnt + 3'd1;
              end
            end else if (StorageReady) begin
              StorageReadEnable <= 1'b1;
              pending           <= 1'b1;
              pend_cnt          <= 3'd0;
            end else if (StorageState == 2'b01) begin
              Done  <= 1'b1;
              state <= DONE;
            end
          end
          DONE: begin
            Busy  <= 1'b0;
            state <= IDLE;
          end
          ERROR: begin
            if (seq_cnt == 2'd3) begin
              StorageReset <= 1'b0;
              Busy         <= 1'b0;
              state        <= IDLE;
            end else begin
              seq_cnt <= seq_cnt + 2'd1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: storage model, byte scoreboard and pulse monitors.
`timescale 1ns/1ps
module tb_capture_sequencer;

  logic        Clock = 1'b0;
  logic        Reset, ArmCmd, AbortCmd, AutoTrigger, TriggerIn, TxReady;
  logic [11:0] SampleWords;
  logic [1:0]  StorageState;
  logic        StorageReady, StorageValid;
  logic [7:0]  StorageData;
  logic        StorageReset, WriteStrobe, StorageReadEnable, TxValid, Busy, Done, Error;
  logic [11:0] ProgFullThresh;
  logic [7:0]  TxData;
  logic [15:0] ByteCount;
  logic [1:0]  ErrorCode;
  logic [2:0]  CtrlState;

  always #5 Clock = ~Clock;

  capture_sequencer #(.THRESH_W(12), .COUNT_W(16), .TIMEOUT_CYCLES(100)) dut (
    .Clock(Clock), .Reset(Reset), .ArmCmd(ArmCmd), .AbortCmd(AbortCmd),
    .AutoTrigger(AutoTrigger), .TriggerIn(TriggerIn), .SampleWords(SampleWords),
    .StorageState(StorageState), .StorageReady(StorageReady), .StorageValid(StorageValid),
    .StorageData(StorageData), .StorageReset(StorageReset), .WriteStrobe(WriteStrobe),
    .ProgFullThresh(ProgFullThresh), .StorageReadEnable(StorageReadEnable), .TxData(TxData),
    .TxValid(TxValid), .TxReady(TxReady), .ByteCount(ByteCount), .Busy(Busy), .Done(Done),
    .Error(Error), .ErrorCode(ErrorCode), .CtrlState(CtrlState)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, err_cnt = 0, re_cnt = 0, ws_cnt = 0, acc_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sb_exp;

  // storage model: registered read, one byte the cycle after each read pulse
  logic [1:0] m_state = 2'b00;
  logic [3:0] m_fill = 4'd0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'd0;
  int         m_rem = 0, m_idx = 0, n_bytes = 0;
  bit         stuck = 1'b0;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  assign StorageState = m_state;
  assign StorageReady = (m_state == 2'b11) && (m_rem > 0);
  assign StorageValid = m_valid;
  assign StorageData  = m_data;

  always @(posedge Clock) begin
    if (Reset || StorageReset) begin
      m_state <= 2'b00; m_valid <= 1'b0; m_rem <= 0; m_fill <= 4'd0;
    end else begin
      m_valid <= 1'b0;
      case (m_state)
        2'b00: m_state <= 2'b01;
        2'b01: if (WriteStrobe) begin m_state <= 2'b10; m_fill <= 4'd0; end
        2'b10: if (!stuck) begin
                 if (m_fill == 4'd10) begin m_state <= 2'b11; m_rem <= n_bytes; m_idx <= 0; end
                 else m_fill <= m_fill + 4'd1;
               end
        default: if (StorageReadEnable && m_rem > 0) begin
                   m_valid <= 1'b1; m_data <= pat(m_idx); m_idx <= m_idx + 1; m_rem <= m_rem - 1;
                 end else if (m_rem == 0 && !m_valid) begin
                   m_state <= 2'b01;
                 end
      endcase
    end
  end

  // scoreboard and pulse monitor
  always @(negedge Clock) begin
    if (!Reset) begin
      if (Done) done_cnt++;
      if (Error) err_cnt++;
      if (StorageReadEnable) re_cnt++;
      if (WriteStrobe) ws_cnt++;
      if (TxValid && TxReady) begin
        checks++;
        acc_cnt++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_byte: got %02h with no byte expected", TxData);
        end else begin
          sb_exp = exp_q.pop_front();
          if (TxData !== sb_exp) begin
            errors++;
            $display("FAIL tx_byte[%0d]: got %02h expected %02h", acc_cnt - 1, TxData, sb_exp);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge Clock); #1; end
  endtask

  task automatic wait_state(input logic [2:0] s, input int max_cyc, input string name);
    int n = 0;
    while (CtrlState !== s && n < max_cyc) begin @(negedge Clock); n++; end
    chk(name, CtrlState, s);
  endtask

  task automatic pulse_arm();
    ArmCmd = 1'b1; step(1); ArmCmd = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sr_cnt, re0, n;
    logic [7:0] hold;
    Reset = 1'b1; ArmCmd = 1'b0; AbortCmd = 1'b0; AutoTrigger = 1'b1; TriggerIn = 1'b0;
    SampleWords = 12'd0; TxReady = 1'b1;
    step(3); Reset = 1'b0; step(1);

    chk("rst_thresh", ProgFullThresh, 2);
    chk("rst_state", CtrlState, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_outputs", {StorageReset, WriteStrobe, StorageReadEnable, TxValid, Done, Error, ErrorCode}, 0);
    chk("rst_bytecount", ByteCount, 0);

    // upper clamp, then abort while waiting for a fill that never finishes
    stuck = 1'b1; SampleWords = 12'd4095;
    pulse_arm();
    chk("clamp_high", ProgFullThresh, 4093);
    chk("arm_flush", StorageReset, 1);
    wait_state(3'd4, 100, "reach_wait_full");
    AbortCmd = 1'b1; step(1); AbortCmd = 1'b0;
    chk("abort_error", Error, 1);
    chk("abort_code", ErrorCode, 1);
    chk("abort_state", CtrlState, 7);
    sr_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (StorageReset) sr_cnt++;
      step(1);
    end
    chk("abort_flush_len", sr_cnt, 4);
    chk("abort_to_idle", CtrlState, 0);
    chk("abort_err_pulses", err_cnt, 1);
    chk("abort_code_held", ErrorCode, 1);

    // arm and abort together in IDLE: nothing happens
    ArmCmd = 1'b1; AbortCmd = 1'b1; step(1); ArmCmd = 1'b0; AbortCmd = 1'b0; step(2);
    chk("armabort_state", CtrlState, 0);
    chk("armabort_busy", Busy, 0);
    chk("armabort_noflush", StorageReset, 0);
    chk("armabort_code", ErrorCode, 1);
    chk("armabort_noerr", err_cnt, 1);

    // lower clamp, then reset mid-flush
    stuck = 1'b0; SampleWords = 12'd0;
    pulse_arm();
    chk("clamp_low", ProgFullThresh, 2);
    chk("arm_clears_code", ErrorCode, 0);
    step(1); Reset = 1'b1; step(1); Reset = 1'b0;
    chk("midreset_state", CtrlState, 0);
    chk("midreset_flush", StorageReset, 0);
    step(5);
    chk("midreset_nopulse", err_cnt + done_cnt, 1);

    // full capture of 68 bytes with a 100-cycle sink stall
    n_bytes = 68; SampleWords = 12'd16; AutoTrigger = 1'b1; ws_cnt = 0; done_cnt = 0; acc_cnt = 0;
    for (int i = 0; i < 68; i++) exp_q.push_back(pat(i));
    pulse_arm();
    chk("cap_thresh", ProgFullThresh, 16);
    n = 0;
    while (acc_cnt < 20 && n < 1000) begin step(1); n++; end
    chk("cap_progress", acc_cnt >= 20, 1);
    TxReady = 1'b0;
    step(10);
    chk("stall_valid", TxValid, 1);
    hold = TxData; re0 = re_cnt;
    step(90);
    chk("stall_valid_held", TxValid, 1);
    chk("stall_data_stable", TxData, hold);
    chk("stall_no_reads", re_cnt - re0, 0);
    TxReady = 1'b1;
    wait_state(3'd6, 2000, "cap_done_state");
    step(3);
    chk("cap_done_pulses", done_cnt, 1);
    chk("cap_bytecount", ByteCount, 68);
    chk("cap_all_bytes", exp_q.size(), 0);
    chk("cap_strobe_len", ws_cnt, 2);
    chk("cap_no_error", err_cnt, 1);
    chk("cap_idle", CtrlState, 0);

    // external trigger: level high before arm must not fire
    AutoTrigger = 1'b0; TriggerIn = 1'b1; n_bytes = 3; ws_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 3; i++) exp_q.push_back(pat(i));
    pulse_arm();
    step(30);
    chk("trig_level_ignored", ws_cnt, 0);
    chk("trig_armed", CtrlState, 2);
    TriggerIn = 1'b0; step(5);
    chk("trig_fall_ignored", ws_cnt, 0);
    TriggerIn = 1'b1; step(1);
    chk("strobe_cycle1", WriteStrobe, 1);
    step(1);
    chk("strobe_cycle2", WriteStrobe, 1);
    step(1);
    chk("strobe_off", WriteStrobe, 0);
    chk("strobe_count", ws_cnt, 2);
    wait_state(3'd6, 500, "trig_done_state");
    step(2);
    chk("trig_done_pulses", done_cnt, 1);
    chk("trig_bytecount", ByteCount, 3);
    chk("trig_all_bytes", exp_q.size(), 0);
    TriggerIn = 1'b0; AutoTrigger = 1'b1;

    // stuck fill: timeout when compiled in, otherwise an indefinite wait
    stuck = 1'b1; err_cnt = 0;
    pulse_arm();
    wait_state(3'd4, 100, "stuck_wait_full");
`ifdef CAPTURE_TIMEOUT_EN
    n = 0;
    while (!Error && n < 200) begin @(negedge Clock); n++; end
    chk("timeout_latency", n, 100);
    chk("timeout_code", ErrorCode, 2);
    wait_state(3'd0, 20, "timeout_idle");
`else
    step(150);
    chk("no_timeout_state", CtrlState, 4);
    chk("no_timeout_error", err_cnt, 0);
    AbortCmd = 1'b1; step(1); AbortCmd = 1'b0;
    wait_state(3'd0, 20, "stuck_abort_idle");
`endif
    stuck = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
